data_sram: RTL and testbench
============================

// Module: data_sram
// PURPOSE
//   Data-memory responder for the load/store pipeline. Services the data_sram_* request bus
//   driven by the EX/MEM stage and returns load data one cycle later, while the MEM/WB side
//   holds the instruction. Supports byte, half and word access, with sign or zero extension
//   and byte-lane stores. A clear FSM zeroes the array after reset.
// PARAMETERS
//   ADDR_WIDTH      10         word-address bits; depth = 2**ADDR_WIDTH words (default 4 KiB)
//   BASE_ADDR       32'h0      byte address of word 0
//   CLEAR_ON_RESET  1          1: zero the whole array after reset; 0: skip straight to RUN
// PORTS
//   clk              in   1   single clock; all state changes on posedge
//   reset            in   1   synchronous, active-low (reset==0 resets at posedge)
//   data_sram_addr   in   32  byte address of the access
//   data_sram_wdata  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//   data_sram_en     in   1   read request
//   data_sram_we     in   1   write request
//   data_sram_mode   in   3   size: 3'b000 byte, 3'b001 half, 3'b010 word; others illegal
//   data_sram_us     in   1   1 = zero-extend the load, 0 = sign-extend
//   data_sram_rdata  out  32  extended load data, valid the cycle after the en cycle
//   data_sram_ready  out  1   1 = in RUN and accepting requests
//   data_sram_err    out  1   one-cycle pulse: misaligned, out-of-range or illegal-mode access
// BEHAVIOUR
// - Reset values (reset==0): rdata=0, ready=0, err=0, clear counter=0, FSM=CLEAR
//   (or RUN when CLEAR_ON_RESET=0). Array contents are not reset directly.
// - FSM CLEAR: writes 32'h0 to word cnt and increments cnt once per cycle. After cnt reaches
//   depth-1, it moves to RUN. ready stays 0 throughout, so ready rises exactly depth cycles
//   after reset is released.
// - FSM RUN: ready=1 and requests are serviced. There is no return from RUN except through reset.
// - In CLEAR, all requests are ignored: no writes, rdata is held at 0, err stays 0.
// - Reset asserted mid-clear restarts the counter at 0 and returns the FSM to CLEAR.
// - Offset = addr - BASE_ADDR (32-bit wrap). Word index = offset[ADDR_WIDTH+1:2].
//   The access is in range iff offset[31:ADDR_WIDTH+2] == 0.
// - An access is legal iff it is in range, the mode is legal, and it is aligned:
//   half needs addr[0]==0, word needs addr[1:0]==0.
// - Store, at posedge with we=1 and a legal access:
//   byte: wdata[7:0] goes to lane addr[1:0];
//   half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1};
//   word: all four lanes are written. Unselected lanes keep their contents.
// - Load, at posedge with en=1: the FSM registers the word, addr[1:0], mode, us and legality.
//   The next cycle rdata = selected lane(s), right-aligned, then sign- or zero-extended per us.
//   An illegal access returns 0. Latency is exactly 1 cycle.
// - rdata holds its last value while en=0.
// - en and we together at the same word is read-first: rdata returns the pre-write contents.
// - Illegal access with en or we set: no array change. err=1 for exactly the following cycle.
//   err never fires when en=we=0.
// - An illegal mode is treated as illegal; it is never silently mapped to word.
// - Little-endian: lane 0 = bits [7:0] = lowest byte address.
// TESTING
// 1. Release reset (depth 1024) -> ready=0 for exactly 1024 cycles, then 1.
//    Word load at 0x40 -> rdata=0x00000000.
// 2. Word store 0xDEADBEEF @0x10, then word load @0x10 -> rdata=0xDEADBEEF one cycle after en.
// 3. Byte store 0x80 @0x13, then:
//    signed byte load @0x13 -> 0xFFFFFF80;
//    unsigned byte load -> 0x00000080;
//    word load @0x10 -> 0x80ADBEEF.
// 4. Signed half load @0x12 -> 0xFFFF80AD; unsigned -> 0x000080AD.
//    Half store @0x11 -> err high one cycle, word @0x10 still 0x80ADBEEF.
// 5. Word store @0x1000 (out of range) -> err pulse, word 0 unchanged.
//    Mode 3'b011 load -> rdata=0, err pulse.
// 6. Drop reset at cycle 500 of CLEAR, hold 1 cycle -> after release, ready low for a full
//    1024 cycles. Same-cycle en+we @0x10 with new data -> rdata=old value, next load=new.

Source files
------------

// File: rtl/data_sram_if.sv
// Request/response bus between the EX/MEM stage (master) and the data memory (slave).
interface data_sram_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic        we;
    logic [2:0]  mode;
    logic        us;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output addr, wdata, en, we, mode, us,
        input  rdata, ready, err
    );

    modport slave (
        input  addr, wdata, en, we, mode, us,
        output rdata, ready, err
    );
endinterface

// File: rtl/data_sram.sv
// Data memory for the load/store pipeline: byte/half/word access with sign or zero
// extension, one-cycle load latency, byte-lane stores and a post-reset clear sweep.
module data_sram #(
    parameter int          ADDR_WIDTH     = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    data_sram_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic                  ready_q;
    logic                  err_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem [DEPTH];

    logic                  borrow;
    logic [29:0]           offset_word;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  in_range;
    logic                  mode_ok;
    logic                  aligned;
    logic                  legal;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_lanes;

    // The word part of (addr - BASE_ADDR) is formed directly so the low offset bits,
    // which the lane logic never needs, are not computed; the borrow keeps it exact
    // even for a BASE_ADDR that is not word aligned.
    assign borrow      = bus.addr[1:0] < BASE_ADDR[1:0];
    assign offset_word = bus.addr[31:2] - BASE_ADDR[31:2] - {29'd0, borrow};
    assign word_idx    = offset_word[ADDR_WIDTH-1:0];
    assign in_range    = (offset_word[29:ADDR_WIDTH] == '0);
    assign lane        = bus.addr[1:0];
    assign legal       = in_range && mode_ok && aligned;

    // Size decode: legality of the mode, alignment, and the lane enables/replicated data for stores.
    always_comb begin
        mode_ok     = 1'b0;
        aligned     = 1'b0;
        byte_en     = 4'b0000;
        wdata_lanes = bus.wdata;
        case (bus.mode)
            3'b000: begin
                mode_ok     = 1'b1;
                aligned     = 1'b1;
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{bus.wdata[7:0]}};
            end
            3'b001: begin
                mode_ok     = 1'b1;
                aligned     = (lane[0] == 1'b0);
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{bus.wdata[15:0]}};
            end
            3'b010: begin
                mode_ok     = 1'b1;
                aligned     = (lane == 2'b00);
                byte_en     = 4'b1111;
                wdata_lanes = bus.wdata;
            end
            default: begin
                mode_ok     = 1'b0;
                aligned     = 1'b0;
                byte_en     = 4'b0000;
                wdata_lanes = bus.wdata;
            end
        endcase
    end

    // Picks the addressed lane(s) out of a stored word and extends them to 32 bits.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  sel,
        input logic [2:0]  mode,
        input logic        us
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = sel[1] ? word[31:16] : word[15:0];
        case (mode)
            3'b000:  extend_load = {{24{b[7] & ~us}}, b};
            3'b001:  extend_load = {{16{h[15] & ~us}}, h};
            3'b010:  extend_load = word;
            default: extend_load = 32'h0;
        endcase
    endfunction

    // Clear/run FSM: sweep every word once after reset, then accept requests until the next reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clear_cnt <= '0;
            ready_q   <= 1'b0;
        end else if (state == ST_CLEAR) begin
            clear_cnt <= clear_cnt + 1'b1;
            if (clear_cnt == {ADDR_WIDTH{1'b1}}) begin
                state   <= ST_RUN;
                ready_q <= 1'b1;
            end
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Load response and error pulse; rdata only moves on an accepted read so it holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            err_q <= ready_q && (bus.en || bus.we) && !legal;
            if (ready_q && bus.en) begin
                rdata_q <= legal ? extend_load(mem[word_idx], lane, bus.mode, bus.us) : 32'h0;
            end
        end
    end

    // Array writes: zeroing during the sweep, lane-masked stores while running. Contents survive reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == ST_CLEAR) begin
                mem[clear_cnt] <= 32'h0;
            end else if (ready_q && bus.we && legal) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                    end
                end
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_data_sram.sv
// Self-checking bench for data_sram: directed scenarios plus randomized traffic
// compared against a byte-addressed reference model.
module tb_data_sram;

    localparam logic [31:0] BASE      = 32'h0;
    localparam int          DEPTH     = 1024;
    localparam int          BYTES     = DEPTH * 4;

    logic clk = 1'b0;
    logic reset;

    data_sram_if bus();

    data_sram #(
        .ADDR_WIDTH    (10),
        .BASE_ADDR     (BASE),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_rdata;
    logic        exp_err;

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int access_size(input logic [2:0] mode);
        case (mode)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_legal(input logic [31:0] addr, input logic [2:0] mode);
        int          size;
        logic [31:0] off;
        size = access_size(mode);
        off  = addr - BASE;
        if (size == 0) return 1'b0;
        if (off >= 32'(BYTES)) return 1'b0;
        if ((addr % 32'(size)) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] mode,
                                               input logic us);
        int          size;
        logic [31:0] off;
        logic [31:0] val;
        logic [31:0] mask;
        if (!model_legal(addr, mode)) return 32'h0;
        size = access_size(mode);
        off  = addr - BASE;
        val  = model_mem[off / 4] >> (8 * (off % 4));
        if (size == 4) return val;
        mask = (32'h1 << (8 * size)) - 32'h1;
        val  = val & mask;
        if (!us && val[8*size-1]) val = val | ~mask;
        return val;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [2:0] mode,
                               input logic [31:0] wdata);
        logic [31:0] off;
        logic [31:0] b;
        if (model_legal(addr, mode)) begin
            off = addr - BASE;
            for (int i = 0; i < access_size(mode); i++) begin
                b = off + 32'(i);
                model_mem[b / 4][8*(b % 4) +: 8] = wdata[8*i +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
    endtask

    task automatic set_idle();
        bus.en    = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.mode  = 3'b010;
        bus.us    = 1'b0;
    endtask

    // Drives one request for one clock edge and updates the model's expectations (read-first).
    task automatic do_access(input bit en, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] mode, input bit us);
        bus.en    = en;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.mode  = mode;
        bus.us    = us;
        exp_err   = (en || we) && !model_legal(addr, mode);
        if (en) exp_rdata = model_load(addr, mode, us);
        if (we) model_store(addr, mode, wdata);
        @(negedge clk);
        set_idle();
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.ready && cycles < 3000);
    endtask

    task automatic test_reset();
        int n;
        set_idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_count++;
        if (bus.rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected %h", bus.rdata, 32'h0);
        else pass_count++;
        check_count++;
        if (bus.ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", bus.ready);
        else pass_count++;
        check_count++;
        if (bus.err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", bus.err);
        else pass_count++;

        reset = 1'b1;
        model_clear();
        wait_ready(n);
        check_count++;
        if (n !== DEPTH) $display("[TB] FAIL clear_length: ready after %0d cycles expected %0d", n, DEPTH);
        else pass_count++;

        do_access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 1'b0);
        check_count++;
        if (bus.rdata !== 32'h0) $display("[TB] FAIL cleared_load: got %h expected %h", bus.rdata, 32'h0);
        else pass_count++;
        check_count++;
        if (bus.err !== 1'b0) $display("[TB] FAIL cleared_load_err: got %b expected 0", bus.err);
        else pass_count++;
    endtask

    task automatic test_word_store();
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
        check_count++;
        if (bus.rdata !== 32'h0) $display("[TB] FAIL rdata_hold: got %h expected %h", bus.rdata, 32'h0);
        else pass_count++;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        check_count++;
        if (bus.rdata !== 32'hDEADBEEF) $display("[TB] FAIL word_load: got %h expected %h", bus.rdata, 32'hDEADBEEF);
        else pass_count++;
    endtask

    task automatic test_byte_lanes();
        do_access(1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000, 1'b0);
        do_access(1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 1'b0);
        check_count++;
        if (bus.rdata !== 32'hFFFFFF80) $display("[TB] FAIL byte_signed: got %h expected %h", bus.rdata, 32'hFFFFFF80);
        else pass_count++;
        do_access(1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 1'b1);
        check_count++;
        if (bus.rdata !== 32'h00000080) $display("[TB] FAIL byte_unsigned: got %h expected %h", bus.rdata, 32'h00000080);
        else pass_count++;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        check_count++;
        if (bus.rdata !== 32'h80ADBEEF) $display("[TB] FAIL byte_merge: got %h expected %h", bus.rdata, 32'h80ADBEEF);
        else pass_count++;
    endtask

    task automatic test_half();
        do_access(1'b1, 1'b0, 32'h12, 32'h0, 3'b001, 1'b0);
        check_count++;
        if (bus.rdata !== 32'hFFFF80AD) $display("[TB] FAIL half_signed: got %h expected %h", bus.rdata, 32'hFFFF80AD);
        else pass_count++;
        do_access(1'b1, 1'b0, 32'h12, 32'h0, 3'b001, 1'b1);
        check_count++;
        if (bus.rdata !== 32'h000080AD) $display("[TB] FAIL half_unsigned: got %h expected %h", bus.rdata, 32'h000080AD);
        else pass_count++;
        do_access(1'b0, 1'b1, 32'h11, 32'h00001234, 3'b001, 1'b0);
        check_count++;
        if (bus.err !== 1'b1) $display("[TB] FAIL half_misaligned_err: got %b expected 1", bus.err);
        else pass_count++;
        @(negedge clk);
        check_count++;
        if (bus.err !== 1'b0) $display("[TB] FAIL err_one_cycle: got %b expected 0", bus.err);
        else pass_count++;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        check_count++;
        if (bus.rdata !== 32'h80ADBEEF) $display("[TB] FAIL misaligned_no_write: got %h expected %h", bus.rdata, 32'h80ADBEEF);
        else pass_count++;
    endtask

    task automatic test_illegal();
        do_access(1'b0, 1'b1, 32'h0, 32'h12345678, 3'b010, 1'b0);
        do_access(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 3'b010, 1'b0);
        check_count++;
        if (bus.err !== 1'b1) $display("[TB] FAIL range_err: got %b expected 1", bus.err);
        else pass_count++;
        do_access(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
        check_count++;
        if (bus.rdata !== 32'h12345678) $display("[TB] FAIL range_no_write: got %h expected %h", bus.rdata, 32'h12345678);
        else pass_count++;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 1'b0);
        check_count++;
        if (bus.rdata !== 32'h0) $display("[TB] FAIL bad_mode_rdata: got %h expected %h", bus.rdata, 32'h0);
        else pass_count++;
        check_count++;
        if (bus.err !== 1'b1) $display("[TB] FAIL bad_mode_err: got %b expected 1", bus.err);
        else pass_count++;
        do_access(1'b0, 1'b0, 32'h1001, 32'h0, 3'b111, 1'b0);
        check_count++;
        if (bus.err !== 1'b0) $display("[TB] FAIL idle_no_err: got %b expected 0", bus.err);
        else pass_count++;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        bus.en   = 1'b1;
        bus.we   = 1'b1;
        bus.addr = 32'h1003;
        bus.mode = 3'b111;
        @(negedge clk);
        set_idle();
        check_count++;
        if (bus.err !== 1'b0) $display("[TB] FAIL clear_ignores_err: got %b expected 0", bus.err);
        else pass_count++;
        check_count++;
        if (bus.rdata !== 32'h0) $display("[TB] FAIL clear_ignores_rdata: got %h expected %h", bus.rdata, 32'h0);
        else pass_count++;
        repeat (299) @(negedge clk);
        check_count++;
        if (bus.ready !== 1'b0) $display("[TB] FAIL mid_clear_ready: got %b expected 0", bus.ready);
        else pass_count++;

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        wait_ready(n);
        check_count++;
        if (n !== DEPTH) $display("[TB] FAIL restart_clear_length: ready after %0d cycles expected %0d", n, DEPTH);
        else pass_count++;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        check_count++;
        if (bus.rdata !== 32'h0) $display("[TB] FAIL recleared_load: got %h expected %h", bus.rdata, 32'h0);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 32'h10, 32'h11223344, 3'b010, 1'b0);
        do_access(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 3'b010, 1'b0);
        check_count++;
        if (bus.rdata !== 32'h11223344) $display("[TB] FAIL read_first_old: got %h expected %h", bus.rdata, 32'h11223344);
        else pass_count++;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        check_count++;
        if (bus.rdata !== 32'hCAFEF00D) $display("[TB] FAIL read_first_new: got %h expected %h", bus.rdata, 32'hCAFEF00D);
        else pass_count++;
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [2:0]  mode;
        int          r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'hFFC + 32'($urandom_range(0, 7));
            else             addr = 32'($urandom_range(0, 63));
            mode = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom, mode,
                      1'($urandom_range(0, 1)));
            check_count++;
            if (bus.rdata !== exp_rdata)
                $display("[TB] FAIL random_rdata[%0d]: got %h expected %h (addr %h mode %0d)",
                         i, bus.rdata, exp_rdata, addr, mode);
            else pass_count++;
            check_count++;
            if (bus.err !== exp_err)
                $display("[TB] FAIL random_err[%0d]: got %b expected %b (addr %h mode %0d)",
                         i, bus.err, exp_err, addr, mode);
            else pass_count++;
        end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        set_idle();
        reset = 1'b0;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        @(negedge clk);
        test_reset();
        test_word_store();
        test_byte_lanes();
        test_half();
        test_illegal();
        test_reset_mid_clear();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
